// File: rtl/bip_loadable_program_memory.sv
// BIP instruction memory with a byte-stream loader: bytes are packed MSB-first into
// words and written from address 0 until a HLT (all-zero) word arrives or memory fills.
module bip_loadable_program_memory #(
    parameter int NB_DATA            = 16,
    parameter int N_ADDR             = 2048,
    parameter int LOG2_N_INSMEM_ADDR = 11,
    parameter int NB_BYTE            = 8
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_load_start,
    input  logic [NB_BYTE-1:0]            i_byte,
    input  logic                          i_byte_valid,
    output logic                          o_byte_ready,
    output logic                          o_load_busy,
    output logic                          o_load_done,
    output logic                          o_load_error,
    output logic [LOG2_N_INSMEM_ADDR:0]   o_load_words,
    input  logic                          i_enable,
    input  logic [LOG2_N_INSMEM_ADDR-1:0] i_addr,
    output logic [NB_DATA-1:0]            o_data,
    output logic                          o_data_valid
);
    localparam int BPW   = NB_DATA / NB_BYTE;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int AW    = LOG2_N_INSMEM_ADDR;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NB_DATA-1:0]  asm_q, asm_d;
    logic [AW:0]         words_q, words_d;
    logic                err_q, err_d;
    logic [NB_DATA-1:0]  word;
    logic                byte_accept;
    logic                we;
    logic [NB_DATA-1:0]  data_q;
    logic                data_valid_q;

    logic [NB_DATA-1:0]  mem [N_ADDR];

    // Handshake: a byte transfers on an edge where i_byte_valid and o_byte_ready are
    // both high; ready depends only on state, so the source may idle valid at will.
    assign o_byte_ready = (state_q == LOAD);
    assign byte_accept  = i_byte_valid && o_byte_ready;
    assign word         = (asm_q << NB_BYTE) | NB_DATA'(i_byte);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            asm_q   <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            words_q <= words_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        words_d = words_q;
        err_d   = err_q;
        we      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (i_load_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    asm_d   = '0;
                    words_d = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (byte_accept) begin
                    if (cnt_q == CNT_W'(BPW - 1)) begin
                        we      = 1'b1;
                        cnt_d   = '0;
                        asm_d   = '0;
                        ptr_d   = ptr_q + AW'(1);
                        words_d = words_q + (AW + 1)'(1);
                        // HLT takes precedence over the memory-full condition.
                        if (word == '0) begin
                            state_d = DONE;
                            err_d   = 1'b0;
                        end else if (ptr_q == AW'(N_ADDR - 1)) begin
                            state_d = DONE;
                            err_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        asm_d = word;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (we && !i_reset) begin
            mem[ptr_q] <= word;
        end
    end

    // Reads are blocked during LOAD, so the single port never sees a read/write collision.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            if (i_enable && (state_q != LOAD)) begin
                data_valid_q <= 1'b1;
                if (32'(i_addr) < N_ADDR) begin
                    data_q <= mem[i_addr];
                end else begin
                    data_q <= '0;
                end
            end
        end
    end

    assign o_load_busy  = (state_q == LOAD);
    assign o_load_done  = (state_q == DONE);
    assign o_load_error = err_q;
    assign o_load_words = words_q;
    assign o_data       = data_q;
    assign o_data_valid = data_valid_q;
endmodule

// File: tb/tb_bip_loadable_program_memory.sv
// Directed bench for the loadable program memory: a default-size instance plus a
// 4-word instance sharing the same stimulus, for the memory-full and out-of-range cases.
module tb_bip_loadable_program_memory;
  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        enable;
  logic [10:0] addr;

  logic        byte_ready, load_busy, load_done, load_error;
  logic [11:0] load_words;
  logic [15:0] data;
  logic        data_valid;

  logic        s_byte_ready, s_load_busy, s_load_done, s_load_error;
  logic [3:0]  s_load_words;
  logic [15:0] s_data;
  logic        s_data_valid;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  bip_loadable_program_memory dut (
    .i_clock(clk), .i_reset(rst), .i_load_start(load_start),
    .i_byte(byte_in), .i_byte_valid(byte_valid), .o_byte_ready(byte_ready),
    .o_load_busy(load_busy), .o_load_done(load_done), .o_load_error(load_error),
    .o_load_words(load_words), .i_enable(enable), .i_addr(addr),
    .o_data(data), .o_data_valid(data_valid)
  );

  bip_loadable_program_memory #(
    .NB_DATA(16), .N_ADDR(4), .LOG2_N_INSMEM_ADDR(3), .NB_BYTE(8)
  ) dut_s (
    .i_clock(clk), .i_reset(rst), .i_load_start(load_start),
    .i_byte(byte_in), .i_byte_valid(byte_valid), .o_byte_ready(s_byte_ready),
    .o_load_busy(s_load_busy), .o_load_done(s_load_done), .o_load_error(s_load_error),
    .o_load_words(s_load_words), .i_enable(enable), .i_addr(addr[2:0]),
    .o_data(s_data), .o_data_valid(s_data_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  // checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic read_addr(input logic [10:0] a);
    enable = 1'b1;
    addr   = a;
    tick();
    enable = 1'b0;
  endtask

  // scoreboard: pop the next expected word and compare the default instance's read
  task automatic read_check(input string tag, input logic [10:0] a);
    logic [15:0] exp;
    read_addr(a);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check(tag, 32'(data), 32'(exp));
      check({tag, "_valid"}, 32'(data_valid), 32'd1);
    end
  endtask

  logic [7:0] stream [6];
  int         gaps   [6];

  initial begin
    rst = 1'b0; load_start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    enable = 1'b0; addr = '0;
    stream = '{8'h08, 8'h05, 8'h18, 8'h03, 8'h00, 8'h00};
    gaps   = '{0, 2, 0, 3, 1, 0};

    // 1: reset state
    do_reset(2);
    check("rst_data", 32'(data), 32'h0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_busy", 32'(load_busy), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_words", 32'(load_words), 32'd0);
    check("rst_error", 32'(load_error), 32'd0);

    // 2: back-to-back load
    start_load();
    check("t2_busy", 32'(load_busy), 32'd1);
    check("t2_ready", 32'(byte_ready), 32'd1);
    for (int i = 0; i < 6; i++) send_byte(stream[i], 0);
    check("t2_done", 32'(load_done), 32'd1);
    check("t2_ready_after", 32'(byte_ready), 32'd0);
    check("t2_busy_after", 32'(load_busy), 32'd0);
    check("t2_words", 32'(load_words), 32'd3);
    check("t2_error", 32'(load_error), 32'd0);
    read_addr(11'd1);
    check("t2_rd1", 32'(data), 32'h1803);
    check("t2_rd1_valid", 32'(data_valid), 32'd1);
    tick();
    check("t2_hold_data", 32'(data), 32'h1803);
    check("t2_hold_valid", 32'(data_valid), 32'd0);
    exp_q.push_back(16'h0805); exp_q.push_back(16'h0000);
    read_check("t2_mem0", 11'd0);
    read_check("t2_mem2", 11'd2);

    // 3: gapped stream, bytes offered in IDLE are dropped
    do_reset(1);
    check("t3_words_rst", 32'(load_words), 32'd0);
    send_byte(8'hFF, 0);
    check("t3_idle_ready", 32'(byte_ready), 32'd0);
    send_byte(8'hFF, 1);
    check("t3_idle_busy", 32'(load_busy), 32'd0);
    start_load();
    for (int i = 0; i < 6; i++) send_byte(stream[i], gaps[i]);
    check("t3_done", 32'(load_done), 32'd1);
    check("t3_words", 32'(load_words), 32'd3);
    check("t3_error", 32'(load_error), 32'd0);
    exp_q.push_back(16'h0805); exp_q.push_back(16'h0000); exp_q.push_back(16'h1803);
    read_check("t3_mem0", 11'd0);
    read_check("t3_mem2", 11'd2);
    read_check("t3_mem1", 11'd1);

    // 4: small instance fills up before HLT
    start_load();
    for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i), 0);
    check("t4_s_done", 32'(s_load_done), 32'd1);
    check("t4_s_error", 32'(s_load_error), 32'd1);
    check("t4_s_words", 32'(s_load_words), 32'd4);
    check("t4_s_ready", 32'(s_byte_ready), 32'd0);
    send_byte(8'h19, 0);
    send_byte(8'h1A, 0);
    check("t4_s_words_after", 32'(s_load_words), 32'd4);
    check("t4_words_big", 32'(load_words), 32'd5);
    for (int i = 0; i < 4; i++) begin
      read_addr(11'(i));
      check($sformatf("t4_s_mem%0d", i), 32'(s_data), 32'h1112 + 32'(i) * 32'h0202);
      check($sformatf("t4_s_mem%0d_valid", i), 32'(s_data_valid), 32'd1);
    end
    read_addr(11'd5);
    check("t4_s_oob", 32'(s_data), 32'h0);
    check("t4_s_oob_valid", 32'(s_data_valid), 32'd1);

    // 6: reads blocked during LOAD, start ignored mid-load
    enable = 1'b1;
    addr   = 11'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_blk_data%0d", i), 32'(data), 32'h1803);
      check($sformatf("t6_blk_valid%0d", i), 32'(data_valid), 32'd0);
    end
    enable = 1'b0;
    start_load();
    check("t6_busy", 32'(load_busy), 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("t6_words", 32'(load_words), 32'd6);
    check("t6_done", 32'(load_done), 32'd1);
    exp_q.push_back(16'h1112); exp_q.push_back(16'h191A); exp_q.push_back(16'h0000);
    read_check("t6_mem0", 11'd0);
    read_check("t6_mem4", 11'd4);
    read_check("t6_mem5", 11'd5);

    // 5: reset mid-load discards the partial word
    start_load();
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    check("t5_words_mid", 32'(load_words), 32'd1);
    do_reset(1);
    check("t5_words_rst", 32'(load_words), 32'd0);
    check("t5_busy_rst", 32'(load_busy), 32'd0);
    start_load();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("t5_words", 32'(load_words), 32'd1);
    check("t5_done", 32'(load_done), 32'd1);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h1314);
    read_check("t5_mem0", 11'd0);
    read_check("t5_mem1", 11'd1);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
